// File: rtl/multi_oscillator_if.sv
// rtl/multi_oscillator_if.sv - configuration write port of the multi-channel oscillator
interface multi_oscillator_if #(
    parameter int NCH = 4,
    parameter int W   = 16
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           cfg_wr;
    logic [CHW-1:0] cfg_ch;
    logic [W-1:0]   cfg_period;
    logic [W-1:0]   cfg_high;
    logic           cfg_ack;
    logic           cfg_err;

    modport master (
        output cfg_wr, cfg_ch, cfg_period, cfg_high,
        input  cfg_ack, cfg_err
    );

    modport slave (
        input  cfg_wr, cfg_ch, cfg_period, cfg_high,
        output cfg_ack, cfg_err
    );
endinterface

// File: rtl/multi_oscillator.sv
// rtl/multi_oscillator.sv - NCH independent programmable-period/duty square-wave generators
module multi_oscillator #(
    parameter int NCH        = 4,
    parameter int W          = 16,
    parameter int DEF_PERIOD = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NCH-1:0]     en,
    input  logic               sync,
    multi_oscillator_if.slave  cfg,
    output logic [NCH-1:0]     z,
    output logic [NCH-1:0]     rise
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [W-1:0] DEF_P = W'(DEF_PERIOD);
    localparam logic [W-1:0] DEF_H = W'(DEF_PERIOD - DEF_PERIOD / 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } osc_state_e;

    osc_state_e     state_q       [NCH];
    osc_state_e     state_d       [NCH];
    logic [W-1:0]   cnt_q         [NCH];
    logic [W-1:0]   cnt_d         [NCH];
    logic [W-1:0]   period_q      [NCH];
    logic [W-1:0]   period_d      [NCH];
    logic [W-1:0]   high_q        [NCH];
    logic [W-1:0]   high_d        [NCH];
    logic [W-1:0]   pend_period_q [NCH];
    logic [W-1:0]   pend_period_d [NCH];
    logic [W-1:0]   pend_high_q   [NCH];
    logic [W-1:0]   pend_high_d   [NCH];
    logic [NCH-1:0] pend_q;
    logic [NCH-1:0] pend_d;
    logic [NCH-1:0] wr_hit;
    logic [NCH-1:0] z_d;
    logic [NCH-1:0] rise_d;
    logic           cfg_valid;

    // 1 <= high < period already implies period >= 2; both kept for clarity
    assign cfg_valid = cfg.cfg_wr
                    && ({1'b0, cfg.cfg_ch} < (CHW + 1)'(NCH))
                    && (cfg.cfg_period >= W'(2))
                    && (cfg.cfg_high != '0)
                    && (cfg.cfg_high < cfg.cfg_period);

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i]       = state_q[i];
            cnt_d[i]         = cnt_q[i];
            period_d[i]      = period_q[i];
            high_d[i]        = high_q[i];
            pend_period_d[i] = pend_period_q[i];
            pend_high_d[i]   = pend_high_q[i];
            pend_d[i]        = pend_q[i];
            wr_hit[i]        = cfg_valid && (cfg.cfg_ch == CHW'(i));

            if (!en[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
                if (pend_q[i]) begin
                    period_d[i] = pend_period_q[i];
                    high_d[i]   = pend_high_q[i];
                end
                pend_d[i] = 1'b0;
            end else if (sync) begin
                // A write landing in the same cycle as sync takes effect immediately
                state_d[i] = LOW;
                cnt_d[i]   = '0;
                if (wr_hit[i]) begin
                    period_d[i] = cfg.cfg_period;
                    high_d[i]   = cfg.cfg_high;
                end else if (pend_q[i]) begin
                    period_d[i] = pend_period_q[i];
                    high_d[i]   = pend_high_q[i];
                end
                pend_d[i] = 1'b0;
            end else begin
                unique case (state_q[i])
                    IDLE: begin
                        state_d[i] = LOW;
                        cnt_d[i]   = '0;
                    end
                    LOW: begin
                        if (cnt_q[i] == period_q[i] - high_q[i] - W'(1)) begin
                            state_d[i] = HIGH;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + W'(1);
                        end
                    end
                    HIGH: begin
                        if (cnt_q[i] == high_q[i] - W'(1)) begin
                            state_d[i] = LOW;
                            cnt_d[i]   = '0;
                            if (pend_q[i]) begin
                                period_d[i] = pend_period_q[i];
                                high_d[i]   = pend_high_q[i];
                            end
                            pend_d[i] = 1'b0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end

            if (wr_hit[i] && !(en[i] && sync)) begin
                pend_period_d[i] = cfg.cfg_period;
                pend_high_d[i]   = cfg.cfg_high;
                pend_d[i]        = 1'b1;
            end

            z_d[i]    = (state_d[i] == HIGH);
            rise_d[i] = (state_d[i] == HIGH) && (state_q[i] != HIGH);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]       <= IDLE;
                cnt_q[i]         <= '0;
                period_q[i]      <= DEF_P;
                high_q[i]        <= DEF_H;
                pend_period_q[i] <= DEF_P;
                pend_high_q[i]   <= DEF_H;
            end
            pend_q      <= '0;
            z           <= '0;
            rise        <= '0;
            cfg.cfg_ack <= 1'b0;
            cfg.cfg_err <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]       <= state_d[i];
                cnt_q[i]         <= cnt_d[i];
                period_q[i]      <= period_d[i];
                high_q[i]        <= high_d[i];
                pend_period_q[i] <= pend_period_d[i];
                pend_high_q[i]   <= pend_high_d[i];
            end
            pend_q      <= pend_d;
            z           <= z_d;
            rise        <= rise_d;
            cfg.cfg_ack <= cfg_valid;
            cfg.cfg_err <= cfg.cfg_wr && !cfg_valid;
        end
    end
endmodule
